// File: rtl/mem_stream_reader_pkg.sv
// Shared types for the operand-memory stream reader.
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Edges from a read issue to the word being pushed: address register, memory output.
  localparam int RET_LATENCY = 2;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Memory read port plus output stream of the stream reader.
interface mem_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output mem_read_en, mem_read_address, out_valid, out_data, out_last,
    input  mem_data_out, out_ready
  );

  modport slave (
    input  mem_read_en, mem_read_address, out_valid, out_data, out_last,
    output mem_data_out, out_ready
  );
endinterface

// File: rtl/mem_stream_reader_fifo.sv
// Small synchronous FIFO holding returned words with their last flag.
module mem_stream_reader_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads `length` words from a 1-cycle-latency memory and streams them out with backpressure.
// Optional: define MEM_STREAM_READER_CHECKSUM_EN to add a running checksum output.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 5,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
`ifdef MEM_STREAM_READER_CHECKSUM_EN
  output logic [DATA_WIDTH+LEN_WIDTH-1:0] checksum,
`endif
  mem_stream_reader_if.master   bus
);

  localparam int CW  = $clog2(OUT_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issued;
  logic [RET_LATENCY-1:0]  rd_vld;
  logic [RET_LATENCY-1:0]  rd_last;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH:0]     fifo_dout;
  logic                    push;
  logic                    pop;
  logic                    head_last;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [CW1-1:0]          credits_used;
  logic                    issue;
  logic                    iss_last;
  logic [ADDR_WIDTH-1:0]   iss_addr;

  assign head_data    = fifo_dout[DATA_WIDTH-1:0];
  assign head_last    = fifo_dout[DATA_WIDTH];
  assign push         = rd_vld[RET_LATENCY-1];
  assign pop          = !fifo_empty && bus.out_ready;
  // Words already queued plus reads still returning must fit in the FIFO.
  assign credits_used = {1'b0, fifo_count} + CW1'($countones(rd_vld));

  always_comb begin
    issue    = 1'b0;
    iss_addr = base_q + ADDR_WIDTH'(issued);
    iss_last = ((issued + LEN_WIDTH'(1)) == len_q);
    if (state == IDLE) begin
      issue    = start && (length != '0);
      iss_addr = base_addr;
      iss_last = (length == LEN_WIDTH'(1));
    end else if (state == READ) begin
      issue = (issued < len_q) && (credits_used < CW1'(OUT_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      issued  <= '0;
      addr_q  <= '0;
      rd_vld  <= '0;
      rd_last <= '0;
    end else begin
      rd_vld  <= {rd_vld[RET_LATENCY-2:0], issue};
      rd_last <= {rd_last[RET_LATENCY-2:0], iss_last};
      if (issue) addr_q <= iss_addr;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          len_q  <= length;
          if (length == '0) begin
            issued <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            issued <= LEN_WIDTH'(1);
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          if (issue) issued <= issued + LEN_WIDTH'(1);
          if ((issue && iss_last) || (issued == len_q)) state <= DRAIN;
        end
        DRAIN: if (pop && head_last) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (pop)                    checksum <= checksum + (DATA_WIDTH+LEN_WIDTH)'(head_data);
  end
`endif

  mem_stream_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({rd_last[RET_LATENCY-1], bus.mem_data_out}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.mem_read_en      = rd_vld[0];
  assign bus.mem_read_address = addr_q;
  assign bus.out_valid        = !fifo_empty;
  assign bus.out_data         = fifo_empty ? '0 : head_data;
  assign bus.out_last         = !fifo_empty && head_last;

endmodule
